// File: rtl/idelay_tap_ctrl.sv
// rtl/idelay_tap_ctrl.sv - stepped tap loader for a bank of IDELAYE3 primitives in VAR_LOAD mode
//
// Purpose:
//   Accepts one tap-set command at a time over a valid/ready handshake.
//   It walks the selected channel from its current tap to the target in steps
//   of at most STEP_MAX taps, one LOAD pulse per step.  After every LOAD it
//   compares CNTVALUEOUT against the value just loaded, and it ends each
//   command with a one-cycle response pulse.
//
// Optional feature macro: IDELAY_VTC_EN
//   defined   : EN_VTC is high on idle channels.  It is dropped for VTC_WAIT
//               cycles before stepping and raised again for VTC_WAIT cycles
//               after stepping.
//   undefined : dly_en_vtc is tied to all-zeros and both VTC phases take
//               zero cycles.
//
// Ports:
//   ref_clk_400m     in   single clock, shared with the IDELAYE3 CLK pins
//   reset            in   asynchronous active-high reset
//   idelay_rdy       in   IDELAYCTRL RDY; gates acceptance, taints an active command
//   cmd_valid/ready  in/out  command handshake
//   cmd_ch           in   target channel (values >= NUM_CH are rejected)
//   cmd_value        in   target tap
//   rsp_valid        out  one-cycle response pulse
//   rsp_ch           out  channel of the response
//   rsp_value        out  final tap read back (0 for a rejected channel)
//   rsp_err          out  readback mismatch, RDY loss or bad channel
//   busy             out  high whenever the FSM is not idle
//   dly_cntvaluein   out  per-channel CNTVALUEIN, channel k at [k*TAP_W +: TAP_W]
//   dly_load         out  per-channel LOAD pulse
//   dly_en_vtc       out  per-channel EN_VTC
//   dly_cntvalueout  in   per-channel CNTVALUEOUT
module idelay_tap_ctrl #(
  parameter int NUM_CH   = 8,
  parameter int CH_W     = 3,
  parameter int TAP_W    = 9,
  parameter int STEP_MAX = 8,
  parameter int SETTLE   = 4,
  parameter int VTC_WAIT = 10
) (
  input  logic                      ref_clk_400m,
  input  logic                      reset,
  input  logic                      idelay_rdy,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [CH_W-1:0]           cmd_ch,
  input  logic [TAP_W-1:0]          cmd_value,
  output logic                      rsp_valid,
  output logic [CH_W-1:0]           rsp_ch,
  output logic [TAP_W-1:0]          rsp_value,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [NUM_CH*TAP_W-1:0]   dly_cntvaluein,
  output logic [NUM_CH-1:0]         dly_load,
  output logic [NUM_CH-1:0]         dly_en_vtc,
  input  logic [NUM_CH*TAP_W-1:0]   dly_cntvalueout
);

  localparam int CNT_MAX = (SETTLE > VTC_WAIT) ? SETTLE : VTC_WAIT;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CH_W:0]    NUM_CH_X    = (CH_W+1)'(NUM_CH);
  localparam logic [TAP_W-1:0] STEP_T      = TAP_W'(STEP_MAX);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] VTC_LAST    = CNT_W'(VTC_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VTC_OFF,
    S_LOAD,
    S_SETTLE,
    S_CHECK,
    S_VTC_ON,
    S_RESP
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [TAP_W-1:0]          target_q, target_d;
  logic [TAP_W-1:0]          next_q, next_d;
  // Working copy of cur_tap[ch] for the command in flight.
  logic [TAP_W-1:0]          pos_q, pos_d;
  logic                      err_q, err_d;
  logic [TAP_W-1:0]          cur_tap_q [NUM_CH];
  logic [TAP_W-1:0]          cur_tap_d [NUM_CH];
  logic [NUM_CH*TAP_W-1:0]   cntvaluein_q, cntvaluein_d;
  logic [NUM_CH-1:0]         load_q, load_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [CH_W-1:0]           rsp_ch_q, rsp_ch_d;
  logic [TAP_W-1:0]          rsp_value_q, rsp_value_d;
  logic                      rsp_err_q, rsp_err_d;
`ifdef IDELAY_VTC_EN
  logic [NUM_CH-1:0]         en_vtc_q, en_vtc_d;
`endif

  logic [TAP_W-1:0]          cmd_cur;
  logic [TAP_W-1:0]          obs_sel;
  logic [TAP_W-1:0]          load_base;
  logic [TAP_W-1:0]          next_val;
  logic                      enter_load;
  logic                      enter_vtc_on;
  logic                      enter_resp;
  logic                      done_seq;

  // One bounded step from cur toward tgt.  The step is clamped to the
  // remaining distance, so it never overshoots and never wraps.
  function automatic logic [TAP_W-1:0] step_toward(input logic [TAP_W-1:0] cur,
                                                    input logic [TAP_W-1:0] tgt);
    logic [TAP_W-1:0] diff;
    logic [TAP_W-1:0] res;
    if (tgt >= cur) begin
      diff = tgt - cur;
      res  = (diff > STEP_T) ? cur + STEP_T : tgt;
    end else begin
      diff = cur - tgt;
      res  = (diff > STEP_T) ? cur - STEP_T : tgt;
    end
    return res;
  endfunction

  assign cmd_ready = (state_q == S_IDLE) & idelay_rdy & ~reset;

  // The channel muxes are written as compare loops.  This keeps them
  // well-defined when 2**CH_W > NUM_CH.
  always_comb begin
    cmd_cur = '0;
    obs_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cmd_ch == CH_W'(k)) cmd_cur = cur_tap_q[k];
      if (ch_q == CH_W'(k))   obs_sel = dly_cntvalueout[k*TAP_W +: TAP_W];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ch_d         = ch_q;
    target_d     = target_q;
    next_d       = next_q;
    pos_d        = pos_q;
    // If RDY is lost while a command is active, the command still finishes
    // but is reported as failed.
    err_d        = err_q | ((state_q != S_IDLE) & ~idelay_rdy);
    cur_tap_d    = cur_tap_q;
    cntvaluein_d = cntvaluein_q;
    load_d       = '0;
    rsp_valid_d  = 1'b0;
    rsp_ch_d     = rsp_ch_q;
    rsp_value_d  = rsp_value_q;
    rsp_err_d    = rsp_err_q;
`ifdef IDELAY_VTC_EN
    en_vtc_d     = en_vtc_q;
`endif
    enter_load   = 1'b0;
    enter_vtc_on = 1'b0;
    enter_resp   = 1'b0;
    done_seq     = 1'b0;
    load_base    = pos_q;
    next_val     = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if ({1'b0, cmd_ch} >= NUM_CH_X) begin
            // A rejected channel gets an immediate error response.
            // The FSM stays idle and no dly_* output moves.
            rsp_valid_d = 1'b1;
            rsp_ch_d    = cmd_ch;
            rsp_value_d = '0;
            rsp_err_d   = 1'b1;
          end else begin
            ch_d     = cmd_ch;
            target_d = cmd_value;
            pos_d    = cmd_cur;
            err_d    = 1'b0;
            cnt_d    = '0;
`ifdef IDELAY_VTC_EN
            state_d  = S_VTC_OFF;
            for (int k = 0; k < NUM_CH; k++)
              if (cmd_ch == CH_W'(k)) en_vtc_d[k] = 1'b0;
`else
            if (cmd_value == cmd_cur) begin
              enter_resp = 1'b1;
            end else begin
              enter_load = 1'b1;
              load_base  = cmd_cur;
            end
`endif
          end
        end
      end
      S_VTC_OFF: begin
        if (cnt_q == VTC_LAST) begin
          cnt_d = '0;
          if (target_q == pos_q) enter_vtc_on = 1'b1;
          else                   enter_load   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOAD: begin
        state_d = S_SETTLE;
        cnt_d   = '0;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
        else                      cnt_d   = cnt_q + CNT_W'(1);
      end
      S_CHECK: begin
        // The primitive's report is authoritative.  After a mismatch, the
        // next command on this channel starts from what was read back.
        for (int k = 0; k < NUM_CH; k++)
          if (ch_q == CH_W'(k)) cur_tap_d[k] = obs_sel;
        pos_d = obs_sel;
        if (obs_sel != next_q) begin
          err_d    = 1'b1;
          done_seq = 1'b1;
        end else if (next_q == target_q) begin
          done_seq = 1'b1;
        end else begin
          enter_load = 1'b1;
          load_base  = obs_sel;
        end
      end
      S_VTC_ON: begin
        if (cnt_q == VTC_LAST) enter_resp = 1'b1;
        else                   cnt_d      = cnt_q + CNT_W'(1);
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (done_seq) begin
`ifdef IDELAY_VTC_EN
      enter_vtc_on = 1'b1;
`else
      enter_resp   = 1'b1;
`endif
    end

    // The LOAD pulse and CNTVALUEIN are registered on entry to LOAD, so both
    // are valid during the LOAD cycle.  CNTVALUEIN keeps its value afterwards.
    if (enter_load) begin
      next_val = step_toward(load_base, target_d);
      next_d   = next_val;
      state_d  = S_LOAD;
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_d == CH_W'(k)) begin
          cntvaluein_d[k*TAP_W +: TAP_W] = next_val;
          load_d[k]                      = 1'b1;
        end
      end
    end

    if (enter_vtc_on) begin
      state_d = S_VTC_ON;
      cnt_d   = '0;
`ifdef IDELAY_VTC_EN
      for (int k = 0; k < NUM_CH; k++)
        if (ch_q == CH_W'(k)) en_vtc_d[k] = 1'b1;
`endif
    end

    if (enter_resp) begin
      state_d     = S_RESP;
      rsp_valid_d = 1'b1;
      rsp_ch_d    = ch_d;
      rsp_value_d = pos_d;
      rsp_err_d   = err_d;
    end
  end

  always_ff @(posedge ref_clk_400m or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ch_q         <= '0;
      target_q     <= '0;
      next_q       <= '0;
      pos_q        <= '0;
      err_q        <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) cur_tap_q[k] <= '0;
      cntvaluein_q <= '0;
      load_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_ch_q     <= '0;
      rsp_value_q  <= '0;
      rsp_err_q    <= 1'b0;
`ifdef IDELAY_VTC_EN
      en_vtc_q     <= '1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      target_q     <= target_d;
      next_q       <= next_d;
      pos_q        <= pos_d;
      err_q        <= err_d;
      for (int k = 0; k < NUM_CH; k++) cur_tap_q[k] <= cur_tap_d[k];
      cntvaluein_q <= cntvaluein_d;
      load_q       <= load_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_ch_q     <= rsp_ch_d;
      rsp_value_q  <= rsp_value_d;
      rsp_err_q    <= rsp_err_d;
`ifdef IDELAY_VTC_EN
      en_vtc_q     <= en_vtc_d;
`endif
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_ch         = rsp_ch_q;
  assign rsp_value      = rsp_value_q;
  assign rsp_err        = rsp_err_q;
  assign dly_cntvaluein = cntvaluein_q;
  assign dly_load       = load_q;
`ifdef IDELAY_VTC_EN
  assign dly_en_vtc     = en_vtc_q;
`else
  assign dly_en_vtc     = '0;
`endif

endmodule

// File: tb/tb_idelay_tap_ctrl.sv
// tb/tb_idelay_tap_ctrl.sv - self-checking bench for idelay_tap_ctrl
module tb_idelay_tap_ctrl;

  localparam int NUM_CH   = 8;
  localparam int CH_W     = 4;
  localparam int TAP_W    = 9;
  localparam int STEP_MAX = 8;
  localparam int SETTLE   = 4;
  localparam int VTC_WAIT = 10;
`ifdef IDELAY_VTC_EN
  localparam int VTC_CYC = 2 * VTC_WAIT;
  localparam logic [NUM_CH-1:0] VTC_IDLE = '1;
`else
  localparam int VTC_CYC = 0;
  localparam logic [NUM_CH-1:0] VTC_IDLE = '0;
`endif

  logic                    clk;
  logic                    reset;
  logic                    idelay_rdy;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [CH_W-1:0]         cmd_ch;
  logic [TAP_W-1:0]        cmd_value;
  logic                    rsp_valid;
  logic [CH_W-1:0]         rsp_ch;
  logic [TAP_W-1:0]        rsp_value;
  logic                    rsp_err;
  logic                    busy;
  logic [NUM_CH*TAP_W-1:0] dly_cntvaluein;
  logic [NUM_CH-1:0]       dly_load;
  logic [NUM_CH-1:0]       dly_en_vtc;
  logic [NUM_CH*TAP_W-1:0] dly_cntvalueout;
  logic                    fault_en;

  idelay_tap_ctrl #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .TAP_W(TAP_W),
    .STEP_MAX(STEP_MAX), .SETTLE(SETTLE), .VTC_WAIT(VTC_WAIT)
  ) dut (
    .ref_clk_400m(clk), .reset(reset), .idelay_rdy(idelay_rdy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_value(cmd_value),
    .rsp_valid(rsp_valid), .rsp_ch(rsp_ch), .rsp_value(rsp_value), .rsp_err(rsp_err),
    .busy(busy), .dly_cntvaluein(dly_cntvaluein), .dly_load(dly_load),
    .dly_en_vtc(dly_en_vtc), .dly_cntvalueout(dly_cntvalueout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Primitive stand-in: CNTVALUEOUT echoes CNTVALUEIN.  With the fault
  // injected, channel 1 reads back stuck at 5.
  always_comb begin
    dly_cntvalueout = dly_cntvaluein;
    if (fault_en) dly_cntvalueout[1*TAP_W +: TAP_W] = 9'd5;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: the only writer of the observation state.
  int              cycle     = 0;
  int              acc_cnt   = 0;
  int              acc_cycle = 0;
  int              rsp_cnt   = 0;
  int              rsp_cycle = 0;
  logic [CH_W-1:0] r_ch;
  logic [TAP_W-1:0] r_val;
  logic            r_err;
  int              busy_cyc  = 0;
  int              vtc_bad   = 0;
  int              lq_ch[$];
  int              lq_val[$];

  always @(negedge clk) begin
    cycle++;
    if (cmd_valid && cmd_ready) begin
      acc_cnt++;
      acc_cycle = cycle;
    end
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_cycle = cycle;
      r_ch  = rsp_ch;
      r_val = rsp_value;
      r_err = rsp_err;
    end
    if (busy) busy_cyc++;
    for (int k = 0; k < NUM_CH; k++) begin
      if (dly_load[k]) begin
        lq_ch.push_back(k);
        lq_val.push_back(int'(dly_cntvaluein[k*TAP_W +: TAP_W]));
`ifdef IDELAY_VTC_EN
        if (dly_en_vtc[k]) vtc_bad++;
`endif
      end
    end
    if (!busy && dly_en_vtc !== VTC_IDLE) vtc_bad++;
  end

  int model_tap[NUM_CH];

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"},       busy, 0);
    check({pfx, "_cmd_ready"},  cmd_ready, 0);
    check({pfx, "_rsp_valid"},  rsp_valid, 0);
    check({pfx, "_rsp_err"},    rsp_err, 0);
    check({pfx, "_rsp_ch"},     rsp_ch, 0);
    check({pfx, "_rsp_value"},  rsp_value, 0);
    check({pfx, "_dly_load"},   dly_load, 0);
    check({pfx, "_cntvaluein"}, dly_cntvaluein, 0);
    check({pfx, "_en_vtc"},     dly_en_vtc, VTC_IDLE);
  endtask

  task automatic run_cmd(input int ch, input int val, input int hold_rdy, input bit drop_rdy);
    int  exp_val[$];
    int  cur, nxt, rbk, d, s, exp_lat, lb, rb0, ab0, bb0, vb0, i;
    bit  bad, exp_err, drop_eff;
    bad     = (ch >= NUM_CH);
    exp_err = 1'b0;
    cur     = 0;
    if (!bad) begin
      cur = model_tap[ch];
      while (cur != val) begin
        d   = (val > cur) ? val - cur : cur - val;
        s   = (d > STEP_MAX) ? STEP_MAX : d;
        nxt = (val > cur) ? cur + s : cur - s;
        exp_val.push_back(nxt);
        rbk = (fault_en && ch == 1) ? 5 : nxt;
        cur = rbk;
        if (rbk != nxt) begin
          exp_err = 1'b1;
          break;
        end
      end
      exp_lat = VTC_CYC + exp_val.size() * (SETTLE + 2) + 1;
    end else begin
      exp_lat = 1;
    end
    drop_eff = drop_rdy && !bad && (exp_lat > 6);
    if (drop_eff) exp_err = 1'b1;

    @(posedge clk); #1;
    lb  = lq_ch.size();
    rb0 = rsp_cnt;
    ab0 = acc_cnt;
    bb0 = busy_cyc;
    vb0 = vtc_bad;
    cmd_ch    = ch[CH_W-1:0];
    cmd_value = val[TAP_W-1:0];
    cmd_valid = 1'b1;
    if (hold_rdy > 0) begin
      idelay_rdy = 1'b0;
      repeat (hold_rdy) @(posedge clk);
      #1;
      check("rdy_low_ready", cmd_ready, 0);
      check("rdy_low_no_accept", acc_cnt - ab0, 0);
      idelay_rdy = 1'b1;
    end
    for (i = 0; i < 50 && acc_cnt == ab0; i++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("accept", acc_cnt - ab0, 1);

    for (i = 0; i < 1000 && rsp_cnt == rb0; i++) begin
      @(negedge clk); #1;
      if (drop_eff && i == 2) idelay_rdy = 1'b0;
      if (i == 5) idelay_rdy = 1'b1;
    end
    idelay_rdy = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    check("rsp_count", rsp_cnt - rb0, 1);
    check("latency", rsp_cycle - acc_cycle, exp_lat);
    check("rsp_ch", r_ch, ch[CH_W-1:0]);
    check("rsp_value", r_val, bad ? 0 : cur);
    check("rsp_err", r_err, bad ? 1 : exp_err);
    check("load_count", lq_ch.size() - lb, exp_val.size());
    for (int j = 0; j < exp_val.size() && lb + j < lq_ch.size(); j++) begin
      check("load_ch", lq_ch[lb+j], ch);
      check("load_val", lq_val[lb+j], exp_val[j]);
    end
    if (bad) check("bad_busy", busy_cyc - bb0, 0);
    check("en_vtc", vtc_bad - vb0, 0);
    if (!bad) model_tap[ch] = cur;
  endtask

  task automatic reset_mid_settle();
    int lb, rb0, ab0, i;
    @(posedge clk); #1;
    lb  = lq_ch.size();
    rb0 = rsp_cnt;
    ab0 = acc_cnt;
    cmd_ch    = 4'd3;
    cmd_value = 9'd30;
    cmd_valid = 1'b1;
    for (i = 0; i < 50 && acc_cnt == ab0; i++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (i = 0; i < 100 && lq_ch.size() == lb; i++) begin
      @(negedge clk); #1;
    end
    check("rst_saw_load", lq_ch.size() - lb, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    check("rst_no_rsp", rsp_cnt - rb0, 0);
    for (int k = 0; k < NUM_CH; k++) model_tap[k] = 0;
  endtask

  initial begin
    int ch, val, hold;
    bit drop;
    reset      = 1'b1;
    idelay_rdy = 1'b1;
    cmd_valid  = 1'b0;
    cmd_ch     = '0;
    cmd_value  = '0;
    fault_en   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) model_tap[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    run_cmd(5, 0, 0, 0);
    run_cmd(2, 20, 0, 0);
    run_cmd(2, 3, 0, 0);
    run_cmd(9, 100, 0, 0);
    fault_en = 1'b1;
    run_cmd(1, 40, 0, 0);
    fault_en = 1'b0;
    run_cmd(1, 20, 0, 0);
    run_cmd(4, 17, 5, 0);
    run_cmd(6, 50, 0, 1);
    reset_mid_settle();
    run_cmd(3, 20, 0, 0);
    run_cmd(7, 511, 0, 0);
    run_cmd(7, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      ch = $urandom_range(0, 10);
      if (ch < NUM_CH && $urandom_range(0, 3) == 0) begin
        val = model_tap[ch] + $urandom_range(0, 20) - 10;
        if (val < 0) val = 0;
        if (val > 511) val = 511;
      end else begin
        val = $urandom_range(0, 511);
      end
      hold = ($urandom_range(0, 3) == 0) ? 2 : 0;
      drop = (ch < NUM_CH) && ($urandom_range(0, 4) == 0);
      run_cmd(ch, val, hold, drop);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
